// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, mode bit positions and helpers for the SPI master
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

  // Bit positions inside a {cpol, cpha} mode pair
  localparam int CPHA_BIT = 0;
  localparam int CPOL_BIT = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - SCK half-period tick generator; restarts on command accept
module spi_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             restart_in,
  input  logic             run_in,
  input  logic [DIV_W-1:0] div_in,
  output logic             tick_out
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_eff;

  // A divider of zero behaves exactly like one
  assign div_eff  = (div_in == '0) ? DIV_W'(1) : div_in;
  assign tick_out = run_in && (cnt_q == '0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_q <= DIV_W'(1);
      cnt_q <= '0;
    end else if (restart_in) begin
      div_q <= div_eff;
      cnt_q <= div_eff - 1'b1;
    end else if (run_in) begin
      if (cnt_q == '0) cnt_q <= div_q - 1'b1;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - SPI master with runtime mode/length/CS/rate and parallel SDI lanes
module spi_master_multi
  import spi_pkg::*;
#(
  parameter  int MAX_BITS = 32,
  parameter  int N_SDI    = 1,
  parameter  int N_CS     = 4,
  parameter  int DIV_W    = 8,
  localparam int LEN_W    = clog2(MAX_BITS),
  localparam int CS_W     = (clog2(N_CS) > 1) ? clog2(N_CS) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic [MAX_BITS-1:0]       cmd_data_in,
  input  logic [LEN_W-1:0]          cmd_len_in,
  input  logic [CS_W-1:0]           cmd_cs_in,
  input  logic                      cmd_cpol_in,
  input  logic                      cmd_cpha_in,
  input  logic [DIV_W-1:0]          clk_div_in,
  output logic                      rsp_valid_out,
  output logic [N_SDI*MAX_BITS-1:0] rsp_data_out,
  output logic [N_CS-1:0]           spi_scs_n_out,
  output logic                      spi_sck_out,
  output logic                      spi_sdo_out,
  input  logic [N_SDI-1:0]          spi_sdi_in
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BITS - 1);

  spi_state_t state_q, state_d;
  logic                            init_done_q;
  logic [1:0]                      mode_q;
  logic [LEN_W-1:0]                len_q;
  logic [LEN_W:0]                  bit_cnt_q;
  logic [MAX_BITS-1:0]             tx_sr_q;
  logic [N_SDI-1:0][MAX_BITS-1:0]  rx_sr_q;
  logic [N_SDI-1:0][MAX_BITS-1:0]  rx_shift;
  logic [LEN_W-1:0]                len_clamped;
  logic [N_CS-1:0]                 cs_sel;
  logic tick, accept, lead_edge, trail_edge, last_bit, hold_end, sample;

  assign len_clamped = (cmd_len_in > LEN_MAX) ? LEN_MAX : cmd_len_in;

  always_comb begin
    cs_sel = '0;
    for (int i = 0; i < N_CS; i++) cs_sel[i] = (cmd_cs_in == CS_W'(i));
  end

  spi_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .restart_in (accept),
    .run_in     (state_q != ST_IDLE),
    .div_in     (clk_div_in),
    .tick_out   (tick)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (trail_edge && last_bit) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_GAP;
      ST_GAP:   if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Leading edge is the tick that moves SCK away from its idle level
  always_comb begin
    cmd_ready_out = (state_q == ST_IDLE) && init_done_q;
    accept        = cmd_ready_out && cmd_valid_in;
    lead_edge     = (state_q == ST_SHIFT) && tick && (spi_sck_out == mode_q[CPOL_BIT]);
    trail_edge    = (state_q == ST_SHIFT) && tick && (spi_sck_out != mode_q[CPOL_BIT]);
    last_bit      = (bit_cnt_q == {1'b0, len_q});
    hold_end      = (state_q == ST_HOLD) && tick;
    sample        = mode_q[CPHA_BIT] ? trail_edge : lead_edge;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      init_done_q   <= 1'b0;
      mode_q        <= 2'b00;
      len_q         <= '0;
      bit_cnt_q     <= '0;
      tx_sr_q       <= '0;
      rsp_valid_out <= 1'b0;
      spi_scs_n_out <= '1;
      spi_sck_out   <= 1'b0;
      spi_sdo_out   <= 1'b1;
    end else begin
      init_done_q   <= 1'b1;
      rsp_valid_out <= 1'b0;
      if (accept) begin
        mode_q        <= {cmd_cpol_in, cmd_cpha_in};
        len_q         <= len_clamped;
        bit_cnt_q     <= '0;
        tx_sr_q       <= cmd_data_in << (LEN_MAX - len_clamped);
        spi_scs_n_out <= ~cs_sel;
        spi_sck_out   <= cmd_cpol_in;
        spi_sdo_out   <= cmd_cpha_in ? 1'b1 : cmd_data_in[len_clamped];
      end
      if (lead_edge) begin
        spi_sck_out <= ~spi_sck_out;
        if (mode_q[CPHA_BIT]) spi_sdo_out <= tx_sr_q[MAX_BITS-1];
      end
      if (trail_edge) begin
        spi_sck_out <= ~spi_sck_out;
        bit_cnt_q   <= bit_cnt_q + 1'b1;
        tx_sr_q     <= tx_sr_q << 1;
        if (!mode_q[CPHA_BIT] && !last_bit) spi_sdo_out <= tx_sr_q[MAX_BITS-2];
      end
      if (hold_end) begin
        spi_scs_n_out <= '1;
        spi_sdo_out   <= 1'b1;
        rsp_valid_out <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_SDI; k++) begin : g_rx
    assign rx_shift[k] = {rx_sr_q[k][MAX_BITS-2:0], spi_sdi_in[k]};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_sr_q      <= '0;
      rsp_data_out <= '0;
    end else begin
      if (accept)      rx_sr_q <= '0;
      else if (sample) rx_sr_q <= rx_shift;
      if (hold_end) rsp_data_out <= rx_sr_q;
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - directed self-checking bench for spi_master_multi with a 3-lane slave model
module tb_spi_master_multi;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [31:0] cmd_data_in;
  logic [4:0]  cmd_len_in;
  logic [1:0]  cmd_cs_in;
  logic        cmd_cpol_in;
  logic        cmd_cpha_in;
  logic [7:0]  clk_div_in;
  logic        rsp_valid_out;
  logic [95:0] rsp_data_out;
  logic [2:0]  spi_scs_n_out;
  logic        spi_sck_out;
  logic        spi_sdo_out;
  logic [2:0]  spi_sdi_in;

  spi_master_multi #(.MAX_BITS(32), .N_SDI(3), .N_CS(3), .DIV_W(8)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .cmd_valid_in  (cmd_valid_in),
    .cmd_ready_out (cmd_ready_out),
    .cmd_data_in   (cmd_data_in),
    .cmd_len_in    (cmd_len_in),
    .cmd_cs_in     (cmd_cs_in),
    .cmd_cpol_in   (cmd_cpol_in),
    .cmd_cpha_in   (cmd_cpha_in),
    .clk_div_in    (clk_div_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_data_out  (rsp_data_out),
    .spi_scs_n_out (spi_scs_n_out),
    .spi_sck_out   (spi_sck_out),
    .spi_sdo_out   (spi_sdo_out),
    .spi_sdi_in    (spi_sdi_in)
  );

  always #5 clk_in = ~clk_in;

  int          n_vec, n_err;
  logic [31:0] slv_word [3];
  int          slv_idx;
  logic        slv_cpol, slv_cpha, slv_on, sck_prev;
  logic [31:0] mosi_cap;
  int          sck_edges, cs_low, cyc, lat, gap, b;
  logic [2:0]  cs_seen;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_reset(input string pfx);
    chk({pfx, "_ready"}, 128'(cmd_ready_out), 128'(0));
    chk({pfx, "_rsp_valid"}, 128'(rsp_valid_out), 128'(0));
    chk({pfx, "_rsp_data"}, 128'(rsp_data_out), 128'(0));
    chk({pfx, "_cs"}, 128'(spi_scs_n_out), 128'(3'b111));
    chk({pfx, "_sck"}, 128'(spi_sck_out), 128'(0));
    chk({pfx, "_sdo"}, 128'(spi_sdo_out), 128'(1));
  endtask

  task automatic slv_drive();
    if (slv_idx >= 0) begin
      for (int k = 0; k < 3; k++) spi_sdi_in[k] = slv_word[k][slv_idx];
    end
    slv_idx--;
  endtask

  // One clk_in cycle observed at the falling edge; also plays the slave role
  task automatic step();
    @(negedge clk_in);
    cyc++;
    if (spi_scs_n_out != 3'b111) cs_low++;
    cs_seen = cs_seen | ~spi_scs_n_out;
    if (slv_on && spi_sck_out != sck_prev) begin
      sck_edges++;
      if (spi_sck_out != slv_cpol) begin
        if (slv_cpha) slv_drive();
        else          mosi_cap = {mosi_cap[30:0], spi_sdo_out};
      end else begin
        if (slv_cpha) mosi_cap = {mosi_cap[30:0], spi_sdo_out};
        else          slv_drive();
      end
    end
    sck_prev = spi_sck_out;
  endtask

  task automatic issue(input logic [31:0] data, input int len, input int cs,
                       input logic cpol, input logic cpha, input int div,
                       input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                       input logic hold);
    int wb;
    cmd_data_in  = data;
    cmd_len_in   = len[4:0];
    cmd_cs_in    = cs[1:0];
    cmd_cpol_in  = cpol;
    cmd_cpha_in  = cpha;
    clk_div_in   = div[7:0];
    cmd_valid_in = 1'b1;
    slv_word[0] = w0; slv_word[1] = w1; slv_word[2] = w2;
    slv_idx = len; slv_cpol = cpol; slv_cpha = cpha;
    mosi_cap = '0; sck_edges = 0; cs_low = 0; cs_seen = '0; cyc = 0;
    if (!cpha) slv_drive();
    wb = 0;
    while (!cmd_ready_out && wb < 200) begin
      @(negedge clk_in);
      wb++;
    end
    chk("accept_wait", 128'(wb < 200), 128'(1));
    @(posedge clk_in);
    #1;
    if (!hold) cmd_valid_in = 1'b0;
    sck_prev = cpol;
    slv_on   = 1'b1;
    chk("busy_ready", 128'(cmd_ready_out), 128'(0));
  endtask

  task automatic wait_rsp(output int latency);
    latency = -1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (rsp_valid_out) begin
        latency = cyc;
        break;
      end
    end
    slv_on = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n_in = 1'b0; cmd_valid_in = 1'b0; cmd_data_in = '0; cmd_len_in = '0;
    cmd_cs_in = '0; cmd_cpol_in = 1'b0; cmd_cpha_in = 1'b0; clk_div_in = '0;
    spi_sdi_in = '0; slv_on = 1'b0; sck_prev = 1'b0; slv_idx = 0;
    slv_cpol = 1'b0; slv_cpha = 1'b0; mosi_cap = '0; sck_edges = 0;
    cs_low = 0; cs_seen = '0; cyc = 0;
    repeat (3) @(negedge clk_in);
    chk_idle_reset("por");
    rst_n_in = 1'b1;
    #1 chk("por_ready_first", 128'(cmd_ready_out), 128'(0));
    step();
    chk("por_ready_then", 128'(cmd_ready_out), 128'(1));

    // Mode 0, 8 bits, div 4, CS1
    issue(32'hA5, 7, 1, 1'b0, 1'b0, 4, 32'h5A, 32'h0, 32'h0, 1'b0);
    wait_rsp(lat);
    chk("m0_latency", 128'(lat), 128'(73));
    chk("m0_cs_low", 128'(cs_low), 128'(72));
    chk("m0_cs_sel", 128'(cs_seen), 128'(3'b010));
    chk("m0_edges", 128'(sck_edges), 128'(16));
    chk("m0_mosi", 128'(mosi_cap), 128'(32'hA5));
    chk("m0_rx", 128'(rsp_data_out), 128'(96'h5A));
    chk("m0_cs_end", 128'(spi_scs_n_out), 128'(3'b111));
    chk("m0_sck_idle", 128'(spi_sck_out), 128'(0));
    chk("m0_sdo_idle", 128'(spi_sdo_out), 128'(1));

    // Mode 3, 16 bits, div 2, CS0
    issue(32'hBEEF, 15, 0, 1'b1, 1'b1, 2, 32'h1234, 32'hFFFF_0000, 32'h0, 1'b0);
    wait_rsp(lat);
    chk("m3_latency", 128'(lat), 128'(69));
    chk("m3_rx", 128'(rsp_data_out), 128'(96'h1234));
    chk("m3_mosi", 128'(mosi_cap), 128'(32'hBEEF));
    chk("m3_edges", 128'(sck_edges), 128'(32));
    chk("m3_cs_sel", 128'(cs_seen), 128'(3'b001));
    step(); step();
    chk("m3_sck_idle", 128'(spi_sck_out), 128'(1));

    // Mode 1, three lanes, div 3, CS2
    issue(32'h3C, 7, 2, 1'b0, 1'b1, 3, 32'hAB, 32'hCD, 32'hEF, 1'b0);
    wait_rsp(lat);
    chk("m1_latency", 128'(lat), 128'(55));
    chk("m1_rx", 128'(rsp_data_out), 128'({32'hEF, 32'hCD, 32'hAB}));
    chk("m1_mosi", 128'(mosi_cap), 128'(32'h3C));
    chk("m1_edges", 128'(sck_edges), 128'(16));
    chk("m1_cs_sel", 128'(cs_seen), 128'(3'b100));

    // Mode 2, three lanes with junk above the length, out-of-range CS
    issue(32'hC3, 7, 3, 1'b1, 1'b0, 1, 32'hFFFF_FF12, 32'h8000_0034, 32'h7FFF_FF56, 1'b0);
    wait_rsp(lat);
    chk("m2_latency", 128'(lat), 128'(19));
    chk("m2_rx", 128'(rsp_data_out), 128'({32'h56, 32'h34, 32'h12}));
    chk("m2_mosi", 128'(mosi_cap), 128'(32'hC3));
    chk("m2_edges", 128'(sck_edges), 128'(16));
    chk("m2_no_cs", 128'(cs_seen), 128'(3'b000));
    chk("m2_sck_idle", 128'(spi_sck_out), 128'(1));

    // Single bit with div 0 and div 1
    for (int d = 0; d < 2; d++) begin
      issue(32'h1, 0, 0, 1'b0, 1'b0, d, 32'h1, 32'h0, 32'h1, 1'b0);
      wait_rsp(lat);
      chk($sformatf("div%0d_latency", d), 128'(lat), 128'(5));
      chk($sformatf("div%0d_edges", d), 128'(sck_edges), 128'(2));
      chk($sformatf("div%0d_cs_low", d), 128'(cs_low), 128'(4));
      chk($sformatf("div%0d_mosi", d), 128'(mosi_cap), 128'(1));
      chk($sformatf("div%0d_rx", d), 128'(rsp_data_out), 128'({32'h1, 32'h0, 32'h1}));
    end

    // Back-to-back with valid held high
    issue(32'hA, 3, 2, 1'b0, 1'b0, 5, 32'h0, 32'h0, 32'h0, 1'b1);
    wait_rsp(lat);
    chk("b2b_latency", 128'(lat), 128'(51));
    gap = 0;
    while (!cmd_ready_out && gap < 100) begin
      step();
      gap++;
    end
    chk("b2b_gap", 128'(gap), 128'(5));
    @(posedge clk_in);
    #1 cmd_valid_in = 1'b0;
    chk("b2b_cs", 128'(spi_scs_n_out), 128'(3'b011));
    chk("b2b_busy", 128'(cmd_ready_out), 128'(0));
    cyc = 0;
    wait_rsp(lat);
    chk("b2b_latency2", 128'(lat), 128'(51));

    // Reset during bit 3
    issue(32'hF0, 7, 0, 1'b0, 1'b0, 4, 32'hFF, 32'hFF, 32'hFF, 1'b0);
    b = 0;
    while (sck_edges < 7 && b < 1000) begin
      step();
      b++;
    end
    chk("mid_reach", 128'(sck_edges), 128'(7));
    rst_n_in = 1'b0;
    slv_on   = 1'b0;
    #1 chk_idle_reset("mid");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_rsp", 128'(rsp_valid_out), 128'(0));
    end
    rst_n_in = 1'b1;
    #1 chk("mid_ready_first", 128'(cmd_ready_out), 128'(0));
    step();
    chk("mid_ready_then", 128'(cmd_ready_out), 128'(1));
    chk("mid_cs_after", 128'(spi_scs_n_out), 128'(3'b111));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
